// File: rtl/mux16_rr_scheduler.sv
// Round-robin burst scheduler driving the select of a 16:1 32-bit mux.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req, last       - per-requester request and last-beat flags
//   out_ready       - downstream accepts the current beat
//   sel_i_16, gnt   - registered mux select and one-hot grant
//   out_valid, ack  - beat valid toward consumer, per-requester accept pulse
//   busy            - a grant is currently held
module mux16_rr_scheduler #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic [15:0] last,
    input  logic        out_ready,
    output logic [3:0]  sel_i_16,
    output logic [15:0] gnt,
    output logic        out_valid,
    output logic [15:0] ack,
    output logic        busy
);

    localparam logic [3:0] MAX_B = MAX_BURST[3:0];

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  ptr;
    logic [3:0]  beats;
    logic [3:0]  beats_inc;

    logic [3:0]  pick;
    logic        pick_vld;
    logic [3:0]  scan_idx;

    logic        req_sel;
    logic        last_sel;
    logic        accept;
    logic        cap_hit;
    logic        end_grant;

    // Scan from ptr upward with 4-bit wraparound. Iterating from the
    // farthest offset down lets the nearest set bit win.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            scan_idx = ptr + 4'(i);
            if (req[scan_idx]) begin
                pick     = scan_idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign req_sel   = req[sel_i_16];
    assign last_sel  = last[sel_i_16];
    assign accept    = (gnt != '0) && req_sel && out_ready;
    assign beats_inc = beats + 4'd1;
    assign cap_hit   = (beats_inc == MAX_B);

    // Withdrawal ends the grant without a beat; otherwise an accepted
    // beat ends it on last or on reaching the burst cap (once if both).
    assign end_grant = (state == GRANT)
                     && (!req_sel || (accept && (last_sel || cap_hit)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (end_grant) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, select, pointer and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            sel_i_16 <= '0;
            ptr      <= '0;
            beats    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        sel_i_16 <= pick;
                        gnt      <= 16'(1) << pick;
                        beats    <= '0;
                    end
                end
                GRANT: begin
                    if (end_grant) begin
                        gnt <= '0;
                        ptr <= sel_i_16 + 4'd1;
                    end else if (accept) begin
                        beats <= beats_inc;
                    end
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

    // Outputs; ack is suppressed while reset is asserted so an in-flight
    // beat is never reported as taken on the reset edge.
    always_comb begin
        busy      = (state == GRANT);
        out_valid = (gnt != '0) && req_sel;
        ack       = (accept && !rst) ? gnt : '0;
    end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Testbench for mux16_rr_scheduler: cycle model plus directed scenarios.
// Prints one TB_RESULT summary line.
module tb_mux16_rr_scheduler;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [15:0] last;
    logic        out_ready;
    logic [3:0]  sel_i_16;
    logic [15:0] gnt;
    logic        out_valid;
    logic [15:0] ack;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state: owner is the granted requester, -1 when none.
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    mux16_rr_scheduler #(.MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .sel_i_16  (sel_i_16),
        .gnt       (gnt),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model advanced on each rising edge.
    always @(posedge clk) begin
        int own, sel, ptr, bts;
        own = m_owner;
        sel = m_sel;
        ptr = m_ptr;
        bts = m_beats;
        if (rst) begin
            own = -1; sel = 0; ptr = 0; bts = 0;
        end else if (own < 0) begin
            for (int k = 0; k < 16; k++) begin
                if (own < 0 && req[(ptr + k) % 16]) begin
                    own = (ptr + k) % 16;
                    sel = own;
                    bts = 0;
                end
            end
        end else begin
            if (!req[own]) begin
                ptr = (own + 1) % 16;
                own = -1;
            end else if (out_ready) begin
                bts = bts + 1;
                if (last[own] || bts == MAXB) begin
                    ptr = (own + 1) % 16;
                    own = -1;
                end
            end
        end
        m_owner <= own;
        m_sel   <= sel;
        m_ptr   <= ptr;
        m_beats <= bts;
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic [15:0] e_gnt;
        logic        e_vld;
        logic [15:0] e_ack;
        if (chk_en) begin
            e_gnt = (m_owner < 0) ? 16'h0 : (16'h1 << m_owner);
            e_vld = (m_owner >= 0) && req[m_sel];
            e_ack = (e_vld && out_ready && !rst) ? (16'h1 << m_sel) : 16'h0;
            chk("m_gnt", 32'(gnt), 32'(e_gnt));
            chk("m_sel", 32'(sel_i_16), 32'(m_sel));
            chk("m_valid", 32'(out_valid), 32'(e_vld));
            chk("m_ack", 32'(ack), 32'(e_ack));
            chk("m_busy", 32'(busy), 32'(m_owner >= 0));
        end
    end

    initial begin
        int n2, n8, n3;
        rst = 1'b1; req = '0; last = '0; out_ready = 1'b0;

        // Reset / idle
        cycle();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_sel", 32'(sel_i_16), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        cycle();
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_sel", 32'(sel_i_16), 0);
            chk("idle_busy", 32'(busy), 0);
            cycle();
        end

        // Single requester, last on third beat
        req = 16'h0020; out_ready = 1'b1;
        @(negedge clk);
        chk("single_wait", 32'(busy), 0);
        cycle();
        for (int b = 0; b < 3; b++) begin
            if (b == 2) last = 16'h0020;
            @(negedge clk);
            chk("single_sel", 32'(sel_i_16), 5);
            chk("single_ack", 32'(ack), 32'h20);
            cycle();
        end
        last = '0; req = 16'h0060;
        @(negedge clk);
        chk("single_idle", 32'(busy), 0);
        chk("single_hold", 32'(sel_i_16), 5);
        cycle();
        req = '0;
        @(negedge clk);
        chk("single_ptr6", 32'(sel_i_16), 6);
        cycle();
        rst = 1'b1; cycle(); rst = 1'b0;

        // Round-robin fairness between 0 and 15
        req = 16'h8001; last = 16'hFFFF; out_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk("rr_bubble", 32'(busy), 0);
            cycle();
            @(negedge clk);
            chk("rr_sel", 32'(sel_i_16), (g % 2 == 1) ? 15 : 0);
            chk("rr_ack", 32'(ack), (g % 2 == 1) ? 32'h8000 : 32'h1);
            cycle();
        end
        req = '0; last = '0;
        rst = 1'b1; cycle(); rst = 1'b0;

        // Burst cap
        req = 16'h0104;
        n2 = 0; n8 = 0;
        repeat (11) begin
            @(negedge clk);
            if (ack == 16'h0004) n2++;
            if (ack == 16'h0100) n8++;
            cycle();
        end
        chk("cap_n2", 32'(n2), 4);
        chk("cap_n8", 32'(n8), 4);
        req = '0;
        rst = 1'b1; cycle(); rst = 1'b0;

        // Backpressure on requester 3
        req = 16'h0008; out_ready = 1'b0;
        cycle();
        repeat (6) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_ack", 32'(ack), 0);
            cycle();
        end
        out_ready = 1'b1;
        n3 = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack == 16'h0008) n3++;
            cycle();
        end
        chk("bp_beats", 32'(n3), 4);
        @(negedge clk);
        chk("bp_end", 32'(busy), 0);
        cycle();
        req = '0;
        rst = 1'b1; cycle(); rst = 1'b0;

        // Withdrawal, then mid-burst reset
        req = 16'h0080;
        cycle();
        @(negedge clk);
        chk("wd_sel", 32'(sel_i_16), 7);
        chk("wd_ack", 32'(ack), 32'h80);
        cycle();
        req = '0;
        @(negedge clk);
        chk("wd_noack", 32'(ack), 0);
        cycle();
        req = 16'h0081;
        cycle();
        @(negedge clk);
        chk("wd_ptr8", 32'(sel_i_16), 0);
        cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack", 32'(ack), 0);
        cycle();
        rst = 1'b0; req = 16'h0180;
        @(negedge clk);
        chk("rst_mid_gnt", 32'(gnt), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        cycle();
        @(negedge clk);
        chk("rst_ptr0", 32'(sel_i_16), 7);
        cycle();
        req = '0;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
